// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the interrupt pending/acknowledge controller:
// state encoding, default overrun counter width and its saturation value.
package irq_pkg;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t IDLE     = 2'd0;
  localparam irq_state_t PENDING  = 2'd1;
  localparam irq_state_t ACK_WAIT = 2'd2;

  localparam int unsigned OVR_W_DEF = 8;

  // Largest value an overrun counter of width w can hold (w <= 32).
  function automatic int unsigned ovr_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Event, acknowledge and mask pins of the interrupt controller plus its status outputs.
// The slave modport is the controller; the master modport is whatever drives it.
interface irq_pending_ctrl_if
  import irq_pkg::*;
#(
  parameter int unsigned OVR_W = OVR_W_DEF
) ();

  logic             irq_in;
  logic             ack_in;
  logic             mask_in;
  logic             irq_out;
  logic             pending;
  logic [OVR_W-1:0] overrun;

  modport master (
    output irq_in,
    output ack_in,
    output mask_in,
    input  irq_out,
    input  pending,
    input  overrun
  );

  modport slave (
    input  irq_in,
    input  ack_in,
    input  mask_in,
    output irq_out,
    output pending,
    output overrun
  );

endinterface

// File: rtl/irq_pending_ctrl_sync_ff.sv
// Multi-flop synchronizer for an asynchronous level input; async active-high reset.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches single-cycle event pulses into a pending state with a maskable registered IRQ pin.
// Define IRQ_OVERRUN_EN to build the saturating lost-event counter; otherwise overrun is 0.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OVR_W       = OVR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  irq_pending_ctrl_if.slave   bus
);

  logic ack_s;
  logic mask_s;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_ack (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (bus.ack_in),
    .q_o  (ack_s)
  );

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_mask (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (bus.mask_in),
    .q_o  (mask_s)
  );

  irq_state_t state_q, state_d;
  logic       requeue_q, requeue_d;
  logic       irq_out_q, irq_out_d;
  logic       lost_evt;

  always_comb begin
    state_d   = state_q;
    requeue_d = requeue_q;
    lost_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.irq_in) state_d = PENDING;
      end
      PENDING: begin
        // A fresh event coinciding with the ack replaces the acked one.
        if (ack_s) begin
          if (!bus.irq_in) state_d = ACK_WAIT;
        end else if (bus.irq_in) begin
          lost_evt = 1'b1;
        end
      end
      ACK_WAIT: begin
        if (bus.irq_in) begin
          if (requeue_q) lost_evt = 1'b1;
          else           requeue_d = 1'b1;
        end
        if (!ack_s) begin
          state_d   = (requeue_q || bus.irq_in) ? PENDING : IDLE;
          requeue_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        requeue_d = 1'b0;
      end
    endcase
    irq_out_d = (state_d == PENDING) && !mask_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      requeue_q <= 1'b0;
      irq_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      requeue_q <= requeue_d;
      irq_out_q <= irq_out_d;
    end
  end

  assign bus.irq_out = irq_out_q;
  assign bus.pending = (state_q == PENDING);

`ifdef IRQ_OVERRUN_EN
  localparam logic [OVR_W-1:0] OvrSat = OVR_W'(ovr_sat(OVR_W));

  logic [OVR_W-1:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (lost_evt && (overrun_q != OvrSat)) overrun_d = overrun_q + OVR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;
`else
  logic unused_lost_evt;
  assign unused_lost_evt = lost_evt;
  assign bus.overrun     = '0;
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: per-cycle vector table with a scoreboard queue,
// followed by overrun saturation and asynchronous-reset sequences.
module tb_irq_pending_ctrl;

  localparam int unsigned OVR_W = 8;
`ifdef IRQ_OVERRUN_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  irq_pending_ctrl_if #(.OVR_W(OVR_W)) bus ();

  irq_pending_ctrl #(
    .SYNC_STAGES(2),
    .OVR_W      (OVR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int irq;
    int ack;
    int mask;
    int exp_irq_out;
    int exp_pending;
    int exp_ovr;
  } vec_t;

  typedef struct {
    int irq_out;
    int pending;
    int ovr;
    int idx;
  } exp_t;

  vec_t vecs[46];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check1(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check1({tag, "_irq_out"}, e.idx, 32'(bus.irq_out), e.irq_out);
    check1({tag, "_pending"}, e.idx, 32'(bus.pending), e.pending);
    check1({tag, "_overrun"}, e.idx, 32'(bus.overrun), e.ovr);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic apply(input string tag, input int idx, input int irq, input int ack,
                       input int mask, input int eo, input int ep, input int ovr);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.irq_in  = (irq != 0);
    bus.ack_in  = (ack != 0);
    bus.mask_in = (mask != 0);
    e.irq_out = eo;
    e.pending = ep;
    e.ovr     = OvrEn ? ovr : 0;
    e.idx     = idx;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d]: scoreboard empty, got nothing expected an entry", tag, idx);
    end else begin
      got = sb_q.pop_front();
      check_outputs(tag, got);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t r;
    int   ovr_model;

    bus.irq_in  = 1'b0;
    bus.ack_in  = 1'b0;
    bus.mask_in = 1'b0;

    // Asynchronous assertion with no clock edge involved.
    #2 reset = 1'b1;
    #1;
    r = '{irq_out: 0, pending: 0, ovr: 0, idx: 0};
    check_outputs("reset", r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //          irq ack msk  irq_out pend ovr
    vecs[0]  = '{0, 0, 0,   0, 0, 0};
    vecs[1]  = '{1, 0, 0,   1, 1, 0};
    vecs[2]  = '{0, 0, 0,   1, 1, 0};
    vecs[3]  = '{0, 1, 0,   1, 1, 0};
    vecs[4]  = '{0, 1, 0,   1, 1, 0};
    vecs[5]  = '{0, 1, 0,   0, 0, 0};
    vecs[6]  = '{0, 1, 0,   0, 0, 0};
    vecs[7]  = '{0, 0, 0,   0, 0, 0};
    vecs[8]  = '{0, 0, 0,   0, 0, 0};
    vecs[9]  = '{0, 0, 0,   0, 0, 0};
    vecs[10] = '{1, 0, 0,   1, 1, 0};
    vecs[11] = '{1, 0, 0,   1, 1, 1};
    vecs[12] = '{1, 0, 0,   1, 1, 2};
    vecs[13] = '{0, 0, 0,   1, 1, 2};
    vecs[14] = '{1, 0, 0,   1, 1, 3};
    vecs[15] = '{0, 1, 0,   1, 1, 3};
    vecs[16] = '{0, 1, 0,   1, 1, 3};
    vecs[17] = '{1, 1, 0,   1, 1, 3};
    vecs[18] = '{0, 1, 0,   0, 0, 3};
    vecs[19] = '{1, 1, 0,   0, 0, 3};
    vecs[20] = '{0, 1, 0,   0, 0, 3};
    vecs[21] = '{1, 1, 0,   0, 0, 4};
    vecs[22] = '{0, 0, 0,   0, 0, 4};
    vecs[23] = '{0, 0, 0,   0, 0, 4};
    vecs[24] = '{0, 0, 0,   1, 1, 4};
    vecs[25] = '{0, 0, 1,   1, 1, 4};
    vecs[26] = '{0, 0, 1,   1, 1, 4};
    vecs[27] = '{0, 0, 1,   0, 1, 4};
    vecs[28] = '{1, 0, 1,   0, 1, 5};
    vecs[29] = '{0, 0, 0,   0, 1, 5};
    vecs[30] = '{0, 0, 0,   0, 1, 5};
    vecs[31] = '{0, 0, 0,   1, 1, 5};
    vecs[32] = '{0, 1, 1,   1, 1, 5};
    vecs[33] = '{0, 1, 1,   1, 1, 5};
    vecs[34] = '{0, 0, 1,   0, 0, 5};
    vecs[35] = '{0, 0, 1,   0, 0, 5};
    vecs[36] = '{0, 0, 1,   0, 0, 5};
    vecs[37] = '{1, 0, 1,   0, 1, 5};
    vecs[38] = '{0, 0, 0,   0, 1, 5};
    vecs[39] = '{0, 0, 0,   0, 1, 5};
    vecs[40] = '{0, 0, 0,   1, 1, 5};
    vecs[41] = '{0, 1, 0,   1, 1, 5};
    vecs[42] = '{0, 1, 0,   1, 1, 5};
    vecs[43] = '{0, 0, 0,   0, 0, 5};
    vecs[44] = '{0, 0, 0,   0, 0, 5};
    vecs[45] = '{1, 0, 0,   1, 1, 5};

    for (int i = 0; i < 46; i++) begin
      apply("vec", i, vecs[i].irq, vecs[i].ack, vecs[i].mask,
            vecs[i].exp_irq_out, vecs[i].exp_pending, vecs[i].exp_ovr);
    end

    // Back-to-back lost events while pending: counter must stop at 255.
    ovr_model = 5;
    for (int i = 0; i < 300; i++) begin
      if (ovr_model < 255) ovr_model++;
      apply("sat", i, 1, 0, 0, 1, 1, ovr_model);
    end

    // Load the mask synchronizer, then reset mid-cycle with events still arriving.
    @(negedge clk);
    bus.mask_in = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    r = '{irq_out: 0, pending: 0, ovr: 0, idx: 1};
    check_outputs("async_rst", r);
    @(posedge clk);
    #1;
    r.idx = 2;
    check_outputs("held_rst", r);
    @(negedge clk);
    bus.mask_in = 1'b0;
    bus.irq_in  = 1'b0;
    reset       = 1'b0;

    // A stale mask_s would still read 1 here if reset had not flushed the chain.
    apply("post_rst", 0, 1, 0, 0, 1, 1, 0);
    apply("post_rst", 1, 1, 0, 0, 1, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Interrupt pending/acknowledge controller downstream of the minipit timer. Latches minipit's 1-cycle `interrupting` pulses into a level-sensitive pending state and drives a maskable interrupt pin. Clears pending on an external acknowledge from a pin and counts events lost while an earlier one was outstanding. Sits in the top level between minipit and `uo_out`; ack and mask arrive asynchronously from `ui_in`.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `ack_in`/`mask_in` (legal: 2 or 3)
- `OVR_W`, 8, width of the saturating overrun counter
- `clk` in 1: the single clock, same as minipit's `clk`
- `reset` in 1: asynchronous, active-high reset. Top level drives it with `~rst_n`.
- `irq_in` in 1: event pulse in the `clk` domain (minipit `interrupting`). Every high cycle is one event.
- `ack_in` in 1: asynchronous acknowledge pin, level, active-high
- `mask_in` in 1: asynchronous mask pin, active-high. It suppresses `irq_out` only.
- `irq_out` out 1: registered interrupt request = pending & ~mask
- `pending` out 1: high while FSM in PENDING
- `overrun` out OVR_W: saturating count of lost events

## Operation
- Reset values:
  - FSM IDLE, `requeue`=0
  - all sync flops 0
  - `irq_out`=0, `pending`=0, `overrun`=0
- `ack_in` and `mask_in` each pass through a SYNC_STAGES flop chain. The FSM uses only the synchronized `ack_s`/`mask_s`.
- FSM states: IDLE, PENDING, ACK_WAIT.
- IDLE:
  - `irq_in` → PENDING.
  - `ack_s` is ignored.
- PENDING:
  - `ack_s`=1 and `irq_in`=0 → ACK_WAIT.
  - `ack_s`=1 and `irq_in`=1 → stay PENDING. The new event replaces the acked one; no overrun.
  - `irq_in` with `ack_s`=0 → stay PENDING, overrun+1.
- ACK_WAIT (waits for ack release; prevents one long ack consuming later events):
  - `irq_in` with `requeue`=0 → set `requeue`.
  - `irq_in` with `requeue`=1 → overrun+1.
  - `ack_s`=0 → PENDING if `requeue` (or `irq_in` this cycle), else IDLE. Clear `requeue`.
- Mask:
  - Affects `irq_out` only.
  - Events are still latched and counted while masked.
  - Unmasking with pending set raises `irq_out`.
- Overrun counter saturates at 2^OVR_W−1 (255) and does not wrap. It is cleared only by `reset`.
- Reset mid-operation: all state returns to reset values immediately (async). In-flight ack/mask synchronizer contents are discarded.

## Timing
- `irq_in` high at edge k:
  - state=PENDING after edge k.
  - `irq_out`=1 after edge k, since it is registered from next-state & ~`mask_s`.
- `pending` is decoded from the state register. It is coincident with the state change.
- `ack_in` rise: `ack_s` high after SYNC_STAGES edges. State leaves PENDING at the next edge. `irq_out` falls at that same edge. Total pin-to-`irq_out` latency: SYNC_STAGES+1 edges (3 at default).
- `mask_in` change to `irq_out` change: SYNC_STAGES+1 edges.
- `overrun` increments at the same edge that samples the lost `irq_in`.
- Ack pulses shorter than 2 `clk` periods may be missed. This is accepted; a held ack is required.

## Configuration
- `IRQ_OVERRUN_EN`
  - Defined: overrun counter is built as described.
  - Undefined: counter logic is omitted. `overrun` is tied to 0. The port stays present for a stable top-level interface. FSM behaviour is otherwise identical.

## Structure
- Shared package `irq_pkg`:
  - state encoding localparams (IDLE=2'd0, PENDING=2'd1, ACK_WAIT=2'd2)
  - default OVR_W
  - overrun saturation constant
- Sub-module `sync_ff`: parameterised SYNC_STAGES flop chain with async active-high reset. It is instantiated twice (ack, mask).
- Top-level hookup:
  - `irq_in`=minipit `interrupting`
  - `ack_in`=`ui_in[4]`
  - `mask_in`=`ui_in[5]`
  - `irq_out`→`uo_out[1]`

## Test plan
- Reset then single `irq_in` pulse at cycle 10 → `irq_out`=`pending`=1 from cycle 11. Hold ack from cycle 20 → `irq_out` falls after edge 23. Release ack → IDLE 3 edges later, `overrun`=0.
- Three `irq_in` pulses while PENDING with no ack → `overrun`=3, `irq_out` remains 1.
- Ack held; two `irq_in` pulses during ACK_WAIT → `requeue` set, `overrun`=1. Ack release → PENDING, `irq_out`=1.
- `mask_in`=1 before event; `irq_in` pulse → `pending`=1, `irq_out`=0. Drop mask → `irq_out`=1 three edges later.
- 300 pulses with no ack → `overrun` saturates at 255. Assert `reset` mid-stream → all outputs 0 asynchronously. With `IRQ_OVERRUN_EN` undefined, `overrun` stays 0 throughout.
- `irq_in` and `ack_s` high in the same PENDING cycle → stays PENDING, `overrun` unchanged.
